// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the Sargantana L1 instruction cache.
package sargantana_icache_pkg;

  localparam int ICACHE_WORD_W = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } icache_way_state_e;

endpackage

// File: rtl/sargantana_icache_way_bank.sv
// One bank of an icache way: ROWS entries, each made of N_WORDS slices of
// SLICE_W bits. It has a single read/write port, a write enable per slice,
// and a registered read output that keeps its value until the next read.
module sargantana_icache_way_bank #(
  parameter int ROWS    = 128,
  parameter int N_WORDS = 4,
  parameter int SLICE_W = 32,
  localparam int ROW_W   = $clog2(ROWS),
  localparam int ENTRY_W = N_WORDS * SLICE_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [N_WORDS-1:0] wmask_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem [ROWS];

  // Storage update: only the slices whose mask bit is set are written
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if (wmask_i[w]) begin
          mem[row_i][w*SLICE_W +: SLICE_W] <= wdata_i[w*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  // Registered read port that holds the last value read; it is cleared on reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_o <= '0;
    end else if (en_i && !we_i) begin
      rdata_o <= mem[row_i];
    end
  end

endmodule

// File: rtl/sargantana_icache_way_banked.sv
// Banked icache way with a valid/ready request port, word-granular writes
// and a zeroing sweep. The sweep runs once after reset (INIT) and again on
// each flush request (FLUSH).
// Optional feature: define SARGANTANA_ICACHE_WAY_PARITY_EN to store one
// even-parity bit per 32-bit word and report mismatches on rsp_perr_o.
module sargantana_icache_way_banked
  import sargantana_icache_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 256,
  parameter int N_BANKS = 2,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int N_WORDS = DATA_W / ICACHE_WORD_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [N_WORDS-1:0] req_wmask_i,
  input  logic [DATA_W-1:0]  req_data_i,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               rsp_valid_o,
  output logic [DATA_W-1:0]  rsp_data_o
`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
  ,
  output logic               rsp_perr_o
`endif
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int ROWS   = DEPTH / N_BANKS;
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
  localparam int SLICE_W = ICACHE_WORD_W + 1;
`else
  localparam int SLICE_W = ICACHE_WORD_W;
`endif
  localparam int ENTRY_W = N_WORDS * SLICE_W;

  icache_way_state_e  state, state_n;
  logic [ROW_W-1:0]   cnt, cnt_n;
  logic               done_n;
  logic               sweep;
  logic               req_accept;
  logic [BSEL_W-1:0]  req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [BSEL_W-1:0]  rsp_bank_q;
  logic [ENTRY_W-1:0] req_entry;
  logic [ENTRY_W-1:0] rsp_entry;
  logic               bank_we;
  logic [ROW_W-1:0]   bank_row;
  logic [N_WORDS-1:0] bank_wmask;
  logic [ENTRY_W-1:0] bank_wdata;
  logic [N_BANKS-1:0] bank_en;
  logic [ENTRY_W-1:0] bank_rdata [N_BANKS];

  assign sweep       = (state == INIT) || (state == FLUSH);
  assign req_ready_o = (state == IDLE) && !flush_i;
  assign req_accept  = req_valid_i && req_ready_o;

  // The low address bits pick the bank and the remaining bits pick the row
  if (N_BANKS > 1) begin : gen_bank_decode
    assign req_bank = req_addr_i[BANK_W-1:0];
    assign req_row  = req_addr_i[ADDR_W-1:BANK_W];
  end else begin : gen_single_bank
    assign req_bank = '0;
    assign req_row  = req_addr_i;
  end

  // State, sweep counter and done pulse registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= INIT;
      cnt          <= '0;
      flush_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      flush_done_o <= done_n;
    end
  end

  // Sweep sequencing: step through every row, then return to IDLE and pulse done.
  // A flush request that arrives during a sweep is ignored.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      INIT, FLUSH: begin
        if (cnt == ROW_W'(ROWS - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + ROW_W'(1);
        end
      end
      IDLE: begin
        if (flush_i) state_n = FLUSH;
      end
      default: state_n = INIT;
    endcase
  end

  // Pack the request data into storage slices, adding a parity bit when that feature is built
  for (genvar w = 0; w < N_WORDS; w++) begin : gen_pack
    assign req_entry[w*SLICE_W +: ICACHE_WORD_W] = req_data_i[w*ICACHE_WORD_W +: ICACHE_WORD_W];
`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
    assign req_entry[w*SLICE_W + ICACHE_WORD_W] = ^req_data_i[w*ICACHE_WORD_W +: ICACHE_WORD_W];
`endif
  end

  // A sweep overrides the request port: it writes all-zero slices to the same row of every bank
  assign bank_we    = sweep || req_we_i;
  assign bank_row   = sweep ? cnt : req_row;
  assign bank_wmask = sweep ? '1 : req_wmask_i;
  assign bank_wdata = sweep ? '0 : req_entry;

  for (genvar b = 0; b < N_BANKS; b++) begin : gen_bank
    assign bank_en[b] = sweep || (req_accept && (req_bank == BSEL_W'(b)));

    sargantana_icache_way_bank #(
      .ROWS    (ROWS),
      .N_WORDS (N_WORDS),
      .SLICE_W (SLICE_W)
    ) u_bank (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .en_i    (bank_en[b]),
      .we_i    (bank_we),
      .row_i   (bank_row),
      .wmask_i (bank_wmask),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata[b])
    );
  end

  // Response valid and the bank index of the read, both captured on the accepting edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid_o <= 1'b0;
      rsp_bank_q  <= '0;
    end else begin
      rsp_valid_o <= req_accept && !req_we_i;
      if (req_accept && !req_we_i) rsp_bank_q <= req_bank;
    end
  end

  assign rsp_entry = bank_rdata[rsp_bank_q];

  for (genvar w = 0; w < N_WORDS; w++) begin : gen_unpack
    assign rsp_data_o[w*ICACHE_WORD_W +: ICACHE_WORD_W] = rsp_entry[w*SLICE_W +: ICACHE_WORD_W];
  end

`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
  logic [N_WORDS-1:0] word_perr;

  // Even parity: a slice whose data and parity bits XOR to 1 is corrupted
  for (genvar w = 0; w < N_WORDS; w++) begin : gen_parity_check
    assign word_perr[w] = ^rsp_entry[w*SLICE_W +: SLICE_W];
  end

  assign rsp_perr_o = rsp_valid_o && (|word_perr);
`endif

endmodule
